// File: rtl/brick_field_engine.sv
// Brick-field store with a one-brick-per-clock ball collision scanner and a registered
// per-pixel brick lookup. Optional feature macro: BRICK_MULTI_HIT_EN (2-bit hit points per brick).
module brick_field_engine #(
    parameter int ROWS    = 7,
    parameter int COLS    = 28,
    parameter int BRICK_W = 20,
    parameter int BRICK_H = 20,
    parameter int X_OFF   = 40,
    parameter int Y_OFF   = 120,
    parameter int COORD_W = 10,
    parameter int SCORE_W = 8,
    parameter logic [ROWS*COLS-1:0] INIT_PATTERN = {(ROWS*COLS){1'b1}},
    parameter int HP_INIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               chk_valid,
    output logic               chk_ready,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [3:0]         ball_size,
    output logic               res_valid,
    output logic               res_hit,
    output logic               res_flip_x,
    output logic               res_flip_y,
    output logic [3:0]         res_destroyed,
    output logic [SCORE_W-1:0] score,
    output logic [8:0]         bricks_left,
    output logic               field_clear,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               pix_brick,
    output logic [1:0]         pix_hp
);
    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int XW = COORD_W + 2;
`ifdef BRICK_MULTI_HIT_EN
    localparam int HPW = 2;
`else
    localparam int HPW = 1;
`endif

    // A zero hit-point setting leaves every brick dead in either build.
    function automatic logic [HPW-1:0] init_hp(input int i);
`ifdef BRICK_MULTI_HIT_EN
        init_hp = (INIT_PATTERN[i] && (HP_INIT != 0)) ? HPW'(HP_INIT) : {HPW{1'b0}};
`else
        init_hp = INIT_PATTERN[i] && (HP_INIT != 0);
`endif
    endfunction

    function automatic logic [8:0] popcount(input logic [N-1:0] v);
        popcount = 9'd0;
        for (int i = 0; i < N; i++) begin
            popcount = popcount + {8'd0, v[i]};
        end
    endfunction

    localparam logic [8:0] INIT_LEFT = (HP_INIT != 0) ? popcount(INIT_PATTERN) : 9'd0;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic [COORD_W-1:0]   bx_q, bx_d, by_q, by_d;
    logic [3:0]           bs_q, bs_d;
    logic                 acc_hit_q, acc_hit_d, acc_fx_q, acc_fx_d, acc_fy_q, acc_fy_d;
    logic [3:0]           acc_dest_q, acc_dest_d;
    logic [HPW-1:0]       hp_q [N];
    logic [HPW-1:0]       hp_d [N];
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [8:0]           left_q, left_d;
    logic                 field_clear_q, field_clear_d;
    logic                 chk_ready_q, chk_ready_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d, res_fx_q, res_fx_d, res_fy_q, res_fy_d;
    logic [3:0]           res_dest_q, res_dest_d;
    logic                 pix_brick_q, pix_brick_d;
    logic [1:0]           pix_hp_q, pix_hp_d;

    logic                 accept_s, overlap_s, top_edge_s, kill_s;
    logic [HPW-1:0]       cur_hp_s;
    logic [XW-1:0]        ball_r_s, ball_b_s, b_left_s, b_right_s, b_top_s, b_bot_s;
    logic [RW-1:0]        prow_s;
    logic [CW-1:0]        pcol_s;
    logic                 prow_hit_s, pcol_hit_s, pix_live_s;
    logic [IW-1:0]        pix_idx_s;
    logic [HPW-1:0]       pix_sel_s;

    // Geometry of the brick currently under the scanner against the latched ball.
    always_comb begin
        cur_hp_s   = hp_q[idx_q];
        ball_r_s   = XW'(bx_q) + XW'(bs_q);
        ball_b_s   = XW'(by_q) + XW'(bs_q);
        b_left_s   = XW'(X_OFF) + XW'(col_q) * XW'(BRICK_W);
        b_right_s  = b_left_s + XW'(BRICK_W);
        b_top_s    = XW'(Y_OFF) + XW'(row_q) * XW'(BRICK_H);
        b_bot_s    = b_top_s + XW'(BRICK_H);
        overlap_s  = (cur_hp_s != {HPW{1'b0}}) && (ball_r_s >= b_left_s) && (XW'(bx_q) <= b_right_s)
                     && (ball_b_s >= b_top_s) && (XW'(by_q) <= b_bot_s);
        top_edge_s = (ball_b_s <= b_top_s + XW'(2)) || (XW'(by_q) + XW'(2) >= b_bot_s);
        kill_s     = overlap_s && (cur_hp_s == HPW'(1));
    end

    // Scan sequencing, field update, counters and result capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        bx_d        = bx_q;
        by_d        = by_q;
        bs_d        = bs_q;
        acc_hit_d   = acc_hit_q;
        acc_fx_d    = acc_fx_q;
        acc_fy_d    = acc_fy_q;
        acc_dest_d  = acc_dest_q;
        hp_d        = hp_q;
        score_d     = score_q;
        left_d      = left_q;
        chk_ready_d = chk_ready_q;
        res_valid_d = 1'b0;
        res_hit_d   = res_hit_q;
        res_fx_d    = res_fx_q;
        res_fy_d    = res_fy_q;
        res_dest_d  = res_dest_q;
        accept_s    = chk_valid && chk_ready_q && (state_q == IDLE);
        if (load) begin
            state_d     = IDLE;
            for (int i = 0; i < N; i++) begin
                hp_d[i] = init_hp(i);
            end
            score_d     = {SCORE_W{1'b0}};
            left_d      = INIT_LEFT;
            chk_ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready drops on acceptance and re-arms one cycle after a result.
                    chk_ready_d = !accept_s;
                    if (accept_s) begin
                        state_d    = SCAN;
                        idx_d      = {IW{1'b0}};
                        row_d      = {RW{1'b0}};
                        col_d      = {CW{1'b0}};
                        bx_d       = ball_x;
                        by_d       = ball_y;
                        bs_d       = ball_size;
                        acc_hit_d  = 1'b0;
                        acc_fx_d   = 1'b0;
                        acc_fy_d   = 1'b0;
                        acc_dest_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    chk_ready_d = 1'b0;
                    if (overlap_s) begin
                        acc_hit_d   = 1'b1;
                        hp_d[idx_q] = cur_hp_s - HPW'(1);
                        if (top_edge_s) begin
                            acc_fy_d = 1'b1;
                        end else begin
                            acc_fx_d = 1'b1;
                        end
                        if (kill_s) begin
                            score_d    = (score_q != {SCORE_W{1'b1}}) ? score_q + SCORE_W'(1) : score_q;
                            left_d     = (left_q != 9'd0) ? left_q - 9'd1 : left_q;
                            acc_dest_d = (acc_dest_q != 4'hF) ? acc_dest_q + 4'd1 : acc_dest_q;
                        end else begin
                            acc_dest_d = acc_dest_q;
                        end
                    end else begin
                        acc_hit_d = acc_hit_q;
                    end
                    if (idx_q == IW'(N - 1)) begin
                        state_d = RESULT;
                    end else if (col_q == CW'(COLS - 1)) begin
                        idx_d = idx_q + IW'(1);
                        col_d = {CW{1'b0}};
                        row_d = row_q + RW'(1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                        col_d = col_q + CW'(1);
                    end
                end
                RESULT: begin
                    state_d     = IDLE;
                    chk_ready_d = 1'b0;
                    res_valid_d = 1'b1;
                    res_hit_d   = acc_hit_q;
                    res_fx_d    = acc_fx_q;
                    res_fy_d    = acc_fy_q;
                    res_dest_d  = acc_dest_q;
                end
                default: begin
                    state_d     = IDLE;
                    chk_ready_d = 1'b1;
                end
            endcase
        end
        field_clear_d = (left_d == 9'd0);
    end

    // Render lookup on half-open brick cells so neighbours never share a pixel.
    always_comb begin
        prow_s     = {RW{1'b0}};
        pcol_s     = {CW{1'b0}};
        prow_hit_s = 1'b0;
        pcol_hit_s = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if ((XW'(pix_x) >= XW'(X_OFF + c * BRICK_W)) && (XW'(pix_x) < XW'(X_OFF + (c + 1) * BRICK_W))) begin
                pcol_hit_s = 1'b1;
                pcol_s     = CW'(c);
            end else begin
                pcol_hit_s = pcol_hit_s;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if ((XW'(pix_y) >= XW'(Y_OFF + r * BRICK_H)) && (XW'(pix_y) < XW'(Y_OFF + (r + 1) * BRICK_H))) begin
                prow_hit_s = 1'b1;
                prow_s     = RW'(r);
            end else begin
                prow_hit_s = prow_hit_s;
            end
        end
        pix_idx_s   = IW'(prow_s) * IW'(COLS) + IW'(pcol_s);
        pix_sel_s   = hp_q[pix_idx_s];
        pix_live_s  = prow_hit_s && pcol_hit_s && (pix_sel_s != {HPW{1'b0}});
        pix_brick_d = pix_live_s;
`ifdef BRICK_MULTI_HIT_EN
        pix_hp_d    = pix_live_s ? pix_sel_s : 2'b00;
`else
        pix_hp_d    = {1'b0, pix_live_s};
`endif
    end

    // State, field and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= {IW{1'b0}};
            row_q         <= {RW{1'b0}};
            col_q         <= {CW{1'b0}};
            bx_q          <= {COORD_W{1'b0}};
            by_q          <= {COORD_W{1'b0}};
            bs_q          <= 4'd0;
            acc_hit_q     <= 1'b0;
            acc_fx_q      <= 1'b0;
            acc_fy_q      <= 1'b0;
            acc_dest_q    <= 4'd0;
            for (int i = 0; i < N; i++) begin
                hp_q[i] <= init_hp(i);
            end
            score_q       <= {SCORE_W{1'b0}};
            left_q        <= INIT_LEFT;
            field_clear_q <= (INIT_LEFT == 9'd0);
            chk_ready_q   <= 1'b1;
            res_valid_q   <= 1'b0;
            res_hit_q     <= 1'b0;
            res_fx_q      <= 1'b0;
            res_fy_q      <= 1'b0;
            res_dest_q    <= 4'd0;
            pix_brick_q   <= 1'b0;
            pix_hp_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            bs_q          <= bs_d;
            acc_hit_q     <= acc_hit_d;
            acc_fx_q      <= acc_fx_d;
            acc_fy_q      <= acc_fy_d;
            acc_dest_q    <= acc_dest_d;
            hp_q          <= hp_d;
            score_q       <= score_d;
            left_q        <= left_d;
            field_clear_q <= field_clear_d;
            chk_ready_q   <= chk_ready_d;
            res_valid_q   <= res_valid_d;
            res_hit_q     <= res_hit_d;
            res_fx_q      <= res_fx_d;
            res_fy_q      <= res_fy_d;
            res_dest_q    <= res_dest_d;
            pix_brick_q   <= pix_brick_d;
            pix_hp_q      <= pix_hp_d;
        end
    end

    assign chk_ready     = chk_ready_q;
    assign res_valid     = res_valid_q;
    assign res_hit       = res_hit_q;
    assign res_flip_x    = res_fx_q;
    assign res_flip_y    = res_fy_q;
    assign res_destroyed = res_dest_q;
    assign score         = score_q;
    assign bricks_left   = left_q;
    assign field_clear   = field_clear_q;
    assign pix_brick     = pix_brick_q;
    assign pix_hp        = pix_hp_q;
endmodule
